// File: rtl/transmissor_uart_stdout.sv
// transmissor_uart_stdout: snoops data-memory stores to STDOUT_ADDR, queues
// the low byte in a small FIFO and sends each byte as an 8N1 UART frame on tx.
//
// Handshake: there is no backpressure toward the processor. A qualifying store
// (hab_esc=1 and end_esc==STDOUT_ADDR) is accepted whenever the FIFO has room,
// or when a slot frees on the same edge. Otherwise the byte is dropped and
// counted in descartados. The FSM pops the FIFO only when it is non-empty.
module transmissor_uart_stdout #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] STDOUT_ADDR  = 32'h0000_0100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hab_esc,
    input  logic [31:0]                   end_esc,
    input  logic [31:0]                   dado_entr,
    output logic                          tx,
    output logic                          ocupado,
    output logic                          fifo_cheio,
    output logic [$clog2(FIFO_DEPTH):0]   nivel,
    output logic [7:0]                    descartados,
    output logic [1:0]                    estado
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } estado_t;

    estado_t       state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level;
    logic [7:0]    drop_cnt;

    logic          push_req, push, pop, fifo_empty, fifo_full, bit_end;

    // Only the low byte of the store data is transmitted.
    logic          unused_data_bits;
    assign unused_data_bits = ^dado_entr[31:8];

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));

    // A full FIFO still accepts a store when the FSM pops on the same edge.
    assign push_req = hab_esc && (end_esc == STDOUT_ADDR);
    assign push     = push_req && (!fifo_full || pop);

    // Next-state, bit timing and shift-register logic for the UART frame.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            OCIOSO: begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = INICIO;
                end
            end
            INICIO: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    state_n = DADOS;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DADOS: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
                        state_n = PARADA;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARADA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frames: no idle gap after the stop bit.
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = INICIO;
                    end else begin
                        state_n = OCIOSO;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = OCIOSO;
        endcase

        // Line level for the cycle after this edge; registered so tx is glitch-free.
        case (state_n)
            INICIO:  tx_n = 1'b0;
            DADOS:   tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // FSM, bit timer, shift register and registered tx line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OCIOSO;
            cnt   <= '0;
            idx   <= 3'd0;
            shift <= 8'd0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx_q  <= tx_n;
        end
    end

    // FIFO storage; contents need no reset because level qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dado_entr[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating count of stores lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (push_req && !push && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign tx          = tx_q;
    assign ocupado     = (state != OCIOSO) || !fifo_empty;
    assign fifo_cheio  = fifo_full;
    assign nivel       = level;
    assign descartados = drop_cnt;
    assign estado      = state;

endmodule

// File: tb/tb_transmissor_uart_stdout.sv
// Bench for transmissor_uart_stdout: constant vector table, hand sequences for
// the frame/FIFO corner cases, and a randomized run against a timeline model.
module tb_transmissor_uart_stdout;

    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] ADDR = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        hab_esc;
    logic [31:0] end_esc;
    logic [31:0] dado_entr;
    logic        tx;
    logic        ocupado;
    logic        fifo_cheio;
    logic [2:0]  nivel;
    logic [7:0]  descartados;
    logic [1:0]  estado;

    transmissor_uart_stdout #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D),
        .STDOUT_ADDR (ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hab_esc    (hab_esc),
        .end_esc    (end_esc),
        .dado_entr  (dado_entr),
        .tx         (tx),
        .ocupado    (ocupado),
        .fifo_cheio (fifo_cheio),
        .nivel      (nivel),
        .descartados(descartados),
        .estado     (estado)
    );

    // Clock.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a queue of accepted bytes plus the time window of the
    // frame currently on the line. A frame popped at edge P occupies edges
    // P .. P+10*C-1; the next pop may happen at edge P+10*C.
    int         k;
    logic [7:0] exp_q[$];
    int         busy_until;
    int         pop_edge;
    logic [7:0] cur;
    int         exp_desc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        busy_until = 0;
        pop_edge   = 0;
        cur        = 8'd0;
        exp_desc   = 0;
        k          = 0;
    endtask

    task automatic model_edge();
        bit pop_now;
        k++;
        pop_now = (k >= busy_until) && (exp_q.size() > 0);
        if (pop_now) begin
            cur        = exp_q.pop_front();
            pop_edge   = k;
            busy_until = k + 10 * C;
        end
        if (hab_esc && end_esc == ADDR) begin
            if (exp_q.size() < D) exp_q.push_back(dado_entr[7:0]);
            else if (exp_desc < 255) exp_desc++;
        end
    endtask

    task automatic check_model();
        bit   busy;
        logic exp_tx;
        busy   = (k < busy_until);
        exp_tx = busy ? frame_bit(cur, (k - pop_edge) / C) : 1'b1;
        chk("tx", tx, exp_tx);
        chk("nivel", nivel, exp_q.size());
        chk("fifo_cheio", fifo_cheio, exp_q.size() == D);
        chk("ocupado", ocupado, busy || exp_q.size() != 0);
        chk("descartados", descartados, exp_desc);
        chk("estado_ocioso", estado == 2'd0, !busy);
    endtask

    // Driver: apply inputs for one edge, then sample 1 time unit after it.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        hab_esc   = we;
        end_esc   = a;
        dado_entr = d;
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else       model_edge();
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (ocupado === 1'b1 && n < budget) begin
            step(1'b0, 32'd0, 32'd0);
            n++;
        end
        chk("drain_done", ocupado, 1'b0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
        int          nivel;
        logic        tx;
        logic        ocup;
    } vec_t;

    vec_t tbl[8];
    logic line41[10];
    int   n;
    logic [7:0] d_save;

    initial begin
        // Vectors from idle right after reset; expectations hold after each edge.
        tbl[0] = '{1'b1, ADDR + 32'd4,       8'h55, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0200,      8'h77, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, ADDR,               8'h99, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, ADDR ^ 32'h8000_0000, 8'h66, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, ADDR,               8'h41, 1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, ADDR,               8'h00, 0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, ADDR,               8'h42, 1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 32'd0,              8'h00, 1, 1'b0, 1'b1};
        line41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset     = 1'b1;
        hab_esc   = 1'b0;
        end_esc   = 32'd0;
        dado_entr = 32'd0;
        model_reset();
        do_reset();
        chk("rst_tx", tx, 1'b1);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_nivel", nivel, 3'd0);
        chk("rst_descartados", descartados, 8'd0);
        chk("rst_estado", estado, 2'd0);

        // Table: address filtering, capture latency, first pop.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].we, tbl[i].addr, {24'd0, tbl[i].data});
            chk($sformatf("tbl%0d_nivel", i), nivel, tbl[i].nivel);
            chk($sformatf("tbl%0d_tx", i), tx, tbl[i].tx);
            chk($sformatf("tbl%0d_ocupado", i), ocupado, tbl[i].ocup);
        end
        wait_idle(400, n);

        // Single 0x41 frame, bit by bit.
        step(1'b1, ADDR, 32'h41);
        chk("t1_tx_before_pop", tx, 1'b1);
        for (int i = 0; i < 10 * C; i++) begin
            step(1'b0, 32'd0, 32'd0);
            chk($sformatf("t1_line%0d", i), tx, line41[i / C]);
        end
        step(1'b0, 32'd0, 32'd0);
        chk("t1_ocupado_end", ocupado, 1'b0);

        // Six back-to-back stores: one pops, four queue, one drops.
        for (int i = 1; i <= 6; i++) step(1'b1, ADDR, i);
        chk("t3_nivel", nivel, 3'd4);
        chk("t3_cheio", fifo_cheio, 1'b1);
        chk("t3_descartados", descartados, 8'd1);
        wait_idle(400, n);
        chk("t3_drain_cycles", n, 196);

        // Store on the edge where the stop bit ends and a full FIFO pops.
        step(1'b1, ADDR, 32'h10);
        for (int i = 1; i <= 4; i++) step(1'b1, ADDR, 32'h10 + i);
        chk("t4_full", fifo_cheio, 1'b1);
        idle(36);
        chk("t4_nivel_pre", nivel, 3'd4);
        d_save = descartados;
        step(1'b1, ADDR, 32'h15);
        chk("t4_nivel_post", nivel, 3'd4);
        chk("t4_descartados", descartados, d_save);
        chk("t4_start_bit", tx, 1'b0);
        wait_idle(400, n);

        // Reset in the middle of a data bit of 0xA5, with bytes still queued.
        step(1'b1, ADDR, 32'hA5);
        step(1'b1, ADDR, 32'h5A);
        step(1'b1, ADDR, 32'h77);
        idle(8);
        chk("t5_tx_low_before", tx, 1'b0);
        chk("t5_nivel_before", nivel, 3'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_tx", tx, 1'b1);
        chk("t5_async_nivel", nivel, 3'd0);
        chk("t5_async_estado", estado, 2'd0);
        chk("t5_async_ocupado", ocupado, 1'b0);
        model_reset();
        step(1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        step(1'b1, ADDR, 32'h3C);
        wait_idle(400, n);
        chk("t5_clean_cycles", n, 10 * C + 1);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) step(1'b1, ADDR, $urandom);
        chk("t6_saturated", descartados, 8'hFF);
        wait_idle(400, n);

        // Randomized bursts against the model.
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            int pct;
            pct = $urandom_range(0, 100);
            for (int i = 0; i < 80; i++) begin
                logic        we;
                logic [31:0] a;
                we = ($urandom_range(0, 99) < pct);
                case ($urandom_range(0, 3))
                    0, 1:    a = ADDR;
                    2:       a = ADDR ^ (32'd1 << $urandom_range(0, 31));
                    default: a = $urandom;
                endcase
                step(we, a, $urandom);
            end
        end
        wait_idle(600, n);
        chk("final_tx", tx, 1'b1);
        chk("final_nivel", nivel, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
